mem_responder: RTL

- Memory-side responder for the multicycle processor's data and instruction ports; services processor read/write requests.
- 256x8 storage with a data port that answers MemRead/MemWrite requests after a programmable wait-state delay, signalled by a one-cycle mem_ready handshake.
- Registered instruction-fetch port.
- Program-loader write port for filling memory before or between runs.

---
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder.sv | 117 +++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - processor-facing bus of the memory responder: data port, fetch port, loader port
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              mem_ready;
    logic [ADDR_W-1:0] address_pc;
    logic [DATA_W-1:0] q_pc;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              proto_err;

    modport master (
        output MemRead, MemWrite, address, data, address_pc, ld_valid, ld_addr, ld_data,
        input  q, mem_ready, q_pc, ld_ready, proto_err
    );

    modport slave (
        input  MemRead, MemWrite, address, data, address_pc, ld_valid, ld_addr, ld_data,
        output q, mem_ready, q_pc, ld_ready, proto_err
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with data, fetch and loader ports
// Optional access counters (rd_count/wr_count) are built when MEM_STATS_EN is defined.
module mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    mem_responder_if.slave        bus
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic req;
    logic access;
    logic ld_do;

    assign req          = bus.MemRead || bus.MemWrite;
    assign bus.ld_ready = (state == S_IDLE) && !req;
    assign ld_do        = bus.ld_valid && bus.ld_ready;
    // A reset landing on the access edge discards the pending operation.
    assign access       = (state == S_WAIT) && (cnt == 4'd0) && !reset;

    always_ff @(posedge clock) begin
        if (access && op_wr) begin
            mem[lat_addr] <= lat_data;
        end else if (ld_do) begin
            mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    // Fetch reads are non-blocking, so a same-edge write returns the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.q_pc <= '0;
        end else begin
            bus.q_pc <= mem[bus.address_pc];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            op_wr         <= 1'b0;
            lat_addr      <= '0;
            lat_data      <= '0;
            bus.q         <= '0;
            bus.mem_ready <= 1'b0;
            bus.proto_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        lat_addr <= bus.address;
                        lat_data <= bus.data;
                        op_wr    <= bus.MemWrite;
                        cnt      <= 4'(WAIT_CYCLES);
                        state    <= S_WAIT;
                        if (bus.MemRead && bus.MemWrite) begin
                            bus.proto_err <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_wr) begin
                            bus.q <= mem[lat_addr];
                        end
                        bus.mem_ready <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    bus.mem_ready <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    bus.mem_ready <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (access) begin
            if (op_wr && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
            if (!op_wr && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif
endmodule
